// File: rtl/conv_enc_blk_sequencer_if.sv
// Handshake and data bundle between the host/encoder side and the block sequencer.
// The host/encoder side uses the master modport; the sequencer uses the slave modport.
interface conv_enc_blk_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              blk_ready;
    logic              length_sel;
    logic [DATA_W-1:0] tail_byte_in;
    logic              data_valid;
    logic              code_block_length;
    logic [DATA_W-1:0] tail_byte;
    logic              computation_done;
    logic [DATA_W-1:0] q0;
    logic [DATA_W-1:0] q1;
    logic [DATA_W-1:0] q2;
    logic              rdreq_subblock;
    logic              out_valid;
    logic [15:0]       sum0;
    logic [15:0]       sum1;
    logic [15:0]       sum2;
    logic [15:0]       byte_count;
    logic              busy;
    logic              test_done;
    logic              timeout_err;

    modport master (
        output blk_ready, length_sel, tail_byte_in, computation_done, q0, q1, q2,
        input  data_valid, code_block_length, tail_byte, rdreq_subblock, out_valid,
               sum0, sum1, sum2, byte_count, busy, test_done, timeout_err
    );

    modport slave (
        input  blk_ready, length_sel, tail_byte_in, computation_done, q0, q1, q2,
        output data_valid, code_block_length, tail_byte, rdreq_subblock, out_valid,
               sum0, sum1, sum2, byte_count, busy, test_done, timeout_err
    );
endinterface

// File: rtl/conv_enc_blk_sequencer.sv
// Block sequencer for the convolutional encoder: starts a block on a rising
// blk_ready, waits for the encoder, drains N subblock bytes per stream while
// keeping 16-bit wrapping checksums, and reports done or an ENCODE timeout.
module conv_enc_blk_sequencer #(
    parameter int DATA_W      = 8,
    parameter int SHORT_BYTES = 132,
    parameter int LONG_BYTES  = 768,
    parameter int RD_LATENCY  = 1,
    parameter int TIMEOUT_CYC = 1048575
) (
    input logic                   clk,
    input logic                   reset,
    conv_enc_blk_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ENCODE,
        S_DRAIN,
        S_FLUSH,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic                was_ready_q, was_ready_d;
    logic                len_q, len_d;
    logic [DATA_W-1:0]   tail_q, tail_d;
    logic [19:0]         tmo_cnt_q, tmo_cnt_d;
    logic [15:0]         rd_cnt_q, rd_cnt_d;
    logic [RD_LATENCY-1:0] dly_q, dly_d;
    logic [15:0]         sum0_q, sum0_d;
    logic [15:0]         sum1_q, sum1_d;
    logic [15:0]         sum2_q, sum2_d;
    logic [15:0]         byte_count_q, byte_count_d;
    logic                start_evt;
    logic                rdreq;
    logic                cap_vld;

    // Checksum accumulate: zero-extend the byte and wrap modulo 2^16.
    function automatic logic [15:0] wrap_add16(input logic [15:0] acc,
                                               input logic [DATA_W-1:0] b);
        return acc + 16'(b);
    endfunction

    // Next-state, counters, delay line and checksum update.
    always_comb begin
        state_d      = state_q;
        was_ready_d  = bus.blk_ready;
        len_d        = len_q;
        tail_d       = tail_q;
        tmo_cnt_d    = tmo_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        sum0_d       = sum0_q;
        sum1_d       = sum1_q;
        sum2_d       = sum2_q;
        byte_count_d = byte_count_q;
        rdreq        = 1'b0;
        start_evt    = bus.blk_ready & ~was_ready_q;
        cap_vld      = dly_q[RD_LATENCY-1];

        // Read data arrives RD_LATENCY cycles after its strobe.
        if (cap_vld) begin
            sum0_d       = wrap_add16(sum0_q, bus.q0);
            sum1_d       = wrap_add16(sum1_q, bus.q1);
            sum2_d       = wrap_add16(sum2_q, bus.q2);
            byte_count_d = byte_count_q + 16'd1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                // A start while busy never reaches here, so it is dropped, not queued.
                if (start_evt) begin
                    state_d      = S_START;
                    sum0_d       = '0;
                    sum1_d       = '0;
                    sum2_d       = '0;
                    byte_count_d = '0;
                    len_d        = bus.length_sel;
                    tail_d       = bus.tail_byte_in;
                end
            end
            S_START: begin
                tmo_cnt_d = '0;
                state_d   = S_ENCODE;
            end
            S_ENCODE: begin
                // Done takes priority over a timeout in the same cycle.
                if (bus.computation_done) begin
                    state_d  = S_DRAIN;
                    rd_cnt_d = len_q ? 16'(LONG_BYTES) : 16'(SHORT_BYTES);
                end else if (tmo_cnt_q == 20'(TIMEOUT_CYC - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 20'd1;
                end
            end
            S_DRAIN: begin
                rdreq = 1'b1;
                if (rd_cnt_q == 16'd1) begin
                    state_d  = S_FLUSH;
                    rd_cnt_d = 16'(RD_LATENCY - 1);
                end else begin
                    rd_cnt_d = rd_cnt_q - 16'd1;
                end
            end
            S_FLUSH: begin
                // Hold off DONE until the last strobe's data has been summed.
                if (rd_cnt_q == 16'd0) begin
                    state_d = S_DONE;
                end else begin
                    rd_cnt_d = rd_cnt_q - 16'd1;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        dly_d[0] = rdreq;
        for (int i = 1; i < RD_LATENCY; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    // State and datapath registers; reset clears everything including the delay line.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            was_ready_q  <= 1'b0;
            len_q        <= 1'b0;
            tail_q       <= '0;
            tmo_cnt_q    <= '0;
            rd_cnt_q     <= '0;
            dly_q        <= '0;
            sum0_q       <= '0;
            sum1_q       <= '0;
            sum2_q       <= '0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            was_ready_q  <= was_ready_d;
            len_q        <= len_d;
            tail_q       <= tail_d;
            tmo_cnt_q    <= tmo_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            dly_q        <= dly_d;
            sum0_q       <= sum0_d;
            sum1_q       <= sum1_d;
            sum2_q       <= sum2_d;
            byte_count_q <= byte_count_d;
        end
    end

    assign bus.data_valid        = (state_q == S_START);
    assign bus.code_block_length = len_q;
    assign bus.tail_byte         = tail_q;
    assign bus.rdreq_subblock    = rdreq;
    assign bus.out_valid         = cap_vld;
    assign bus.sum0              = sum0_q;
    assign bus.sum1              = sum1_q;
    assign bus.sum2              = sum2_q;
    assign bus.byte_count        = byte_count_q;
    assign bus.busy              = (state_q == S_START) || (state_q == S_ENCODE) ||
                                   (state_q == S_DRAIN) || (state_q == S_FLUSH);
    assign bus.test_done         = (state_q == S_DONE);
    assign bus.timeout_err       = (state_q == S_ERROR);

endmodule

// File: tb/tb_conv_enc_blk_sequencer.sv
// Bench for conv_enc_blk_sequencer: randomized blocks against a behavioural
// memory/responder model, plus directed short/long, re-trigger, timeout and abort cases.
module tb_conv_enc_blk_sequencer;
    localparam int DW = 8;
    localparam int SB = 132;
    localparam int LB = 768;
    localparam int RL = 3;
    localparam int TC = 100;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    conv_enc_blk_sequencer_if #(.DATA_W(DW)) bus();

    conv_enc_blk_sequencer #(
        .DATA_W(DW), .SHORT_BYTES(SB), .LONG_BYTES(LB),
        .RD_LATENCY(RL), .TIMEOUT_CYC(TC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] mem0 [LB];
    logic [7:0] mem1 [LB];
    logic [7:0] mem2 [LB];
    int rd_idx = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected checksum: plain sum of the first n block bytes, modulo 2^16.
    function automatic logic [31:0] exp_sum(input int k, input int n);
        int s = 0;
        for (int i = 0; i < n; i++)
            s += (k == 0) ? int'(mem0[i]) : (k == 1) ? int'(mem1[i]) : int'(mem2[i]);
        return 32'(s % 65536);
    endfunction

    task automatic fill_mem(input int mode);
        for (int i = 0; i < LB; i++) begin
            case (mode)
                0: begin mem0[i] = 8'h01; mem1[i] = 8'h01; mem2[i] = 8'h01; end
                1: begin mem0[i] = 8'hFF; mem1[i] = 8'($urandom); mem2[i] = 8'($urandom); end
                2: begin mem0[i] = 8'(i); mem1[i] = 8'($urandom); mem2[i] = 8'($urandom); end
                default: begin mem0[i] = 8'($urandom); mem1[i] = 8'($urandom); mem2[i] = 8'($urandom); end
            endcase
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ctrl"}, {bus.data_valid, bus.code_block_length, bus.tail_byte,
                  bus.rdreq_subblock, bus.out_valid, bus.busy, bus.test_done, bus.timeout_err}, 0);
        check_val({tag, "_sum0"}, bus.sum0, 0);
        check_val({tag, "_sum1"}, bus.sum1, 0);
        check_val({tag, "_sum2"}, bus.sum2, 0);
        check_val({tag, "_bytes"}, bus.byte_count, 0);
    endtask

    // Encoder-side read memory: answers each strobe RD_LATENCY cycles later,
    // drives noise otherwise, and checks out_valid against that schedule.
    initial begin
        bit hist[$];
        bit h;
        logic r;
        bus.q0 = '0; bus.q1 = '0; bus.q2 = '0;
        for (int i = 0; i < RL; i++) hist.push_back(1'b0);
        forever begin
            @(posedge clk);
            r = reset;
            @(negedge clk);
            if (bus.data_valid) rd_idx = 0;
            hist.push_back(bus.rdreq_subblock);
            h = hist.pop_front();
            if (!r) begin
                hist = {};
                for (int i = 0; i < RL; i++) hist.push_back(1'b0);
                h = 1'b0;
            end
            check_val("out_valid", bus.out_valid, h);
            if (h && rd_idx < LB) begin
                bus.q0 = mem0[rd_idx]; bus.q1 = mem1[rd_idx]; bus.q2 = mem2[rd_idx];
                rd_idx++;
            end else begin
                bus.q0 = 8'($urandom); bus.q1 = 8'($urandom); bus.q2 = 8'($urandom);
            end
        end
    end

    task automatic run_block(input bit len, input logic [7:0] tail, input int dly,
                             input int abort_at, input bit retrig);
        int n = len ? LB : SB;
        int cnt = 0;
        int wait_c = 0;
        int lat = 1;
        logic seen = 1'b0;
        bus.length_sel = len;
        bus.tail_byte_in = tail;
        bus.blk_ready = 1'b1;
        tick();
        check_val("dv_pulse", bus.data_valid, 1);
        check_val("start_len", bus.code_block_length, len);
        check_val("start_tail", bus.tail_byte, tail);
        check_val("start_busy", bus.busy, 1);
        check_val("start_done_clr", bus.test_done, 0);
        check_val("start_sum0_clr", bus.sum0, 0);
        check_val("start_bytes_clr", bus.byte_count, 0);
        bus.length_sel = ~len;
        bus.tail_byte_in = 8'($urandom);
        tick();
        check_val("dv_one_cycle", bus.data_valid, 0);
        for (int i = 0; i < dly; i++) begin
            seen |= bus.rdreq_subblock | bus.timeout_err;
            tick();
        end
        check_val("encode_quiet", seen, 0);
        bus.computation_done = 1'b1;
        tick();
        bus.computation_done = 1'b0;
        check_val("first_rdreq", bus.rdreq_subblock, 1);
        while (bus.rdreq_subblock && wait_c < 2000) begin
            cnt++;
            if (cnt == abort_at) begin
                bus.blk_ready = 1'b0;
                reset = 1'b0;
                tick();
                check_all_zero("abort");
                tick();
                reset = 1'b1;
                seen = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    seen |= bus.rdreq_subblock | bus.busy;
                    tick();
                end
                check_val("abort_quiet", seen, 0);
                return;
            end
            if (retrig && cnt == 10) bus.blk_ready = 1'b0;
            if (retrig && cnt == 12) bus.blk_ready = 1'b1;
            tick();
            wait_c++;
        end
        check_val("rdreq_count", cnt, n);
        while (!bus.test_done && lat < 50) begin
            tick();
            lat++;
        end
        check_val("done_latency", lat, RL + 1);
        check_val("done_busy", bus.busy, 0);
        check_val("byte_count", bus.byte_count, n);
        check_val("sum0", bus.sum0, exp_sum(0, n));
        check_val("sum1", bus.sum1, exp_sum(1, n));
        check_val("sum2", bus.sum2, exp_sum(2, n));
        check_val("held_len", bus.code_block_length, len);
        check_val("held_tail", bus.tail_byte, tail);
        bus.blk_ready = 1'b0;
        tick();
        check_val("done_held", bus.test_done, 1);
    endtask

    task automatic run_timeout();
        logic seen = 1'b0;
        bus.length_sel = 1'($urandom);
        bus.blk_ready = 1'b1;
        tick();
        tick();
        for (int i = 1; i < TC; i++) begin
            seen |= bus.rdreq_subblock;
            tick();
        end
        check_val("tmo_not_yet", bus.timeout_err, 0);
        tick();
        check_val("tmo_flag", bus.timeout_err, 1);
        check_val("tmo_no_rdreq", seen | bus.rdreq_subblock, 0);
        bus.blk_ready = 1'b0;
        tick();
        bus.blk_ready = 1'b1;
        bus.computation_done = 1'b1;
        tick();
        bus.computation_done = 1'b0;
        tick();
        tick();
        check_val("tmo_sticky", {bus.timeout_err, bus.rdreq_subblock, bus.data_valid, bus.busy}, 4'b1000);
        bus.blk_ready = 1'b0;
        reset = 1'b0;
        tick();
        check_val("tmo_cleared", bus.timeout_err, 0);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        bus.blk_ready = 1'b0;
        bus.length_sel = 1'b0;
        bus.tail_byte_in = '0;
        bus.computation_done = 1'b0;
        reset = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        fill_mem(0);
        run_block(1'b0, 8'h00, 49, -1, 1'b0);
        fill_mem(1);
        run_block(1'b1, 8'($urandom), int'($urandom_range(0, 80)), -1, 1'b0);
        fill_mem(3);
        run_block(1'b0, 8'($urandom), 20, -1, 1'b1);
        fill_mem(3);
        run_block(1'b0, 8'($urandom), 99, -1, 1'b0);
        fill_mem(3);
        run_block(1'b1, 8'($urandom), 0, -1, 1'b0);
        run_timeout();
        fill_mem(3);
        run_block(1'b0, 8'($urandom), 10, 60, 1'b0);
        fill_mem(3);
        run_block(1'b0, 8'($urandom), 5, -1, 1'b0);
        fill_mem(2);
        run_block(1'b0, 8'($urandom), 30, -1, 1'b0);
        for (int b = 0; b < 3; b++) begin
            fill_mem(3);
            run_block(1'($urandom), 8'($urandom), int'($urandom_range(0, 99)), -1, 1'($urandom));
        end
        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
